// File: rtl/scalar_mult_ctrl.sv
// Montgomery-ladder sequencer for k*P: drives a shared point_add unit with
// two additions per scalar bit (add, then double) so timing is independent of k.
module scalar_mult_ctrl #(
  parameter int N       = 255,
  parameter int KBITS   = 255,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KBITS-1:0] k,
  input  logic [N-1:0]     px,
  input  logic [N-1:0]     py,
  input  logic [N-1:0]     pz,
  input  logic [N-1:0]     pt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [N-1:0]     qx,
  output logic [N-1:0]     qy,
  output logic [N-1:0]     qz,
  output logic [N-1:0]     qt,
  output logic             pa_en,
  output logic [N-1:0]     pa_x1,
  output logic [N-1:0]     pa_y1,
  output logic [N-1:0]     pa_z1,
  output logic [N-1:0]     pa_t1,
  output logic [N-1:0]     pa_x2,
  output logic [N-1:0]     pa_y2,
  output logic [N-1:0]     pa_z2,
  output logic [N-1:0]     pa_t2,
  input  logic [N-1:0]     pa_x3,
  input  logic [N-1:0]     pa_y3,
  input  logic [N-1:0]     pa_z3,
  input  logic [N-1:0]     pa_t3,
  input  logic             pa_rdy
);

  localparam int IW = (KBITS > 1) ? $clog2(KBITS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  // Packed points are {t, z, y, x}; neutral element is (0, 1, 1, 0).
  localparam logic [3:0][N-1:0] NEUTRAL = {N'(0), N'(1), N'(1), N'(0)};

  typedef enum logic [3:0] {
    IDLE, LOAD, ADD_ISSUE, ADD_WAIT, DBL_ISSUE, DBL_WAIT, NEXT, DONE, ERR
  } state_t;

  state_t                state;
  logic [KBITS-1:0]      k_l;
  logic [3:0][N-1:0]     p_l;
  logic [3:0][N-1:0]     r0;
  logic [3:0][N-1:0]     r1;
  logic [3:0][N-1:0]     op1;
  logic [3:0][N-1:0]     op2;
  logic [3:0][N-1:0]     q;
  logic [3:0][N-1:0]     pa_res;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         wait_cnt;
  logic                  rdy_q;
  logic                  rdy_edge;
  logic                  bit_k;
  logic                  wait_expired;

  assign pa_res       = {pa_t3, pa_z3, pa_y3, pa_x3};
  // Only a fresh rise of data_rdy marks a new result; a level left high is stale.
  assign rdy_edge     = pa_rdy & ~rdy_q;
  assign bit_k        = k_l[idx];
  assign wait_expired = (wait_cnt == CW'(TIMEOUT - 1));

  assign {pa_t1, pa_z1, pa_y1, pa_x1} = op1;
  assign {pa_t2, pa_z2, pa_y2, pa_x2} = op2;
  assign {qt, qz, qy, qx}             = q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pa_en    <= 1'b0;
      k_l      <= '0;
      p_l      <= '0;
      r0       <= '0;
      r1       <= '0;
      op1      <= '0;
      op2      <= '0;
      q        <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= pa_rdy;
      pa_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_l   <= k;
            p_l   <= {pt, pz, py, px};
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          r0       <= NEUTRAL;
          r1       <= p_l;
          idx      <= IW'(KBITS - 1);
          op1      <= NEUTRAL;
          op2      <= p_l;
          pa_en    <= 1'b1;
          wait_cnt <= '0;
          state    <= ADD_ISSUE;
        end
        ADD_ISSUE: state <= ADD_WAIT;
        ADD_WAIT: begin
          if (rdy_edge) begin
            if (bit_k) r0 <= pa_res;
            else       r1 <= pa_res;
            // The register to double is the one the sum did not overwrite.
            op1      <= bit_k ? r1 : r0;
            op2      <= bit_k ? r1 : r0;
            pa_en    <= 1'b1;
            wait_cnt <= '0;
            state    <= DBL_ISSUE;
          end else if (wait_expired) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DBL_ISSUE: state <= DBL_WAIT;
        DBL_WAIT: begin
          if (rdy_edge) begin
            if (bit_k) r1 <= pa_res;
            else       r0 <= pa_res;
            state <= NEXT;
          end else if (wait_expired) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx      <= idx - 1'b1;
            op1      <= r0;
            op2      <= r1;
            pa_en    <= 1'b1;
            wait_cnt <= '0;
            state    <= ADD_ISSUE;
          end
        end
        DONE: begin
          q     <= r0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: a point_add stand-in implements a commutative
// monoid with neutral (0,1,1,0) so k*P has a closed form: (k*x, y^k, z^k, k*t).
module tb_scalar_mult_ctrl;

  localparam int N         = 32;
  localparam int KBITS     = 8;
  localparam int TIMEOUT   = 30;
  localparam int JOB_BOUND = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [KBITS-1:0] k = '0;
  logic [N-1:0]     px = '0, py = '0, pz = '0, pt = '0;
  logic             busy, done, err, pa_en, pa_rdy;
  logic [N-1:0]     qx, qy, qz, qt;
  logic [N-1:0]     pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2;
  logic [N-1:0]     pa_x3, pa_y3, pa_z3, pa_t3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  scalar_mult_ctrl #(.N(N), .KBITS(KBITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k(k),
    .px(px), .py(py), .pz(pz), .pt(pt),
    .busy(busy), .done(done), .err(err),
    .qx(qx), .qy(qy), .qz(qz), .qt(qt),
    .pa_en(pa_en),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_z1(pa_z1), .pa_t1(pa_t1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_z2(pa_z2), .pa_t2(pa_t2),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_z3(pa_z3), .pa_t3(pa_t3),
    .pa_rdy(pa_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // point_add stand-in: result rises lat cycles after pa_en; rdy optionally held
  // high for hold_cfg cycles into the wait with the stale result still shown.
  int           lat_min = 5, lat_max = 5, hold_cfg = 0;
  bit           never_rdy = 1'b0;
  int           op_cnt = 0, lat_sum = 0;
  bit           dbl_eq [8192];
  int           j_cnt, cur_lat;
  bit           pending;
  logic [N-1:0] rx, ry, rz, rt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      pa_rdy  <= 1'b0;
      j_cnt   <= 0;
      cur_lat <= 2;
      pa_x3 <= '0; pa_y3 <= '0; pa_z3 <= '0; pa_t3 <= '0;
    end else if (pa_en) begin
      pending <= 1'b1;
      j_cnt   <= 1;
      cur_lat <= int'($urandom_range(lat_max, lat_min));
      rx <= pa_x1 + pa_x2;
      ry <= pa_y1 * pa_y2;
      rz <= pa_z1 * pa_z2;
      rt <= pa_t1 + pa_t2;
      if (hold_cfg == 0) pa_rdy <= 1'b0;
      dbl_eq[op_cnt % 8192] <= (pa_x1 == pa_x2) && (pa_y1 == pa_y2) &&
                               (pa_z1 == pa_z2) && (pa_t1 == pa_t2);
      op_cnt <= op_cnt + 1;
    end else if (pending) begin
      j_cnt <= j_cnt + 1;
      if (j_cnt == hold_cfg) pa_rdy <= 1'b0;
      if (!never_rdy && (j_cnt + 1 == cur_lat)) begin
        pa_rdy  <= 1'b1;
        pa_x3 <= rx; pa_y3 <= ry; pa_z3 <= rz; pa_t3 <= rt;
        pending <= 1'b0;
        lat_sum <= lat_sum + cur_lat + 1;
      end
    end
  end

  // k-fold repetition of the monoid operation, starting from the neutral point.
  function automatic void ref_mult(input logic [KBITS-1:0] kk,
                                   input logic [N-1:0] x, y, z, t,
                                   output logic [N-1:0] ex, ey, ez, et);
    ex = '0; ey = N'(1); ez = N'(1); et = '0;
    for (int i = 0; i < int'(kk); i++) begin
      ex = ex + x; ey = ey * y; ez = ez * z; et = et + t;
    end
  endfunction

  task automatic run_job(input logic [KBITS-1:0] kk, input logic [N-1:0] x, y, z, t,
                         output int s_cyc, output int d_cyc, output int n_ops,
                         output int lsum, output int op0, output bit b1,
                         output bit e2, output bit timed_out);
    int l0;
    @(negedge clk);
    k = kk; px = x; py = y; pz = z; pt = t; start = 1'b1;
    s_cyc = cyc; op0 = op_cnt; l0 = lat_sum;
    @(negedge clk);
    start = 1'b0; b1 = busy;
    @(negedge clk);
    e2 = pa_en;
    timed_out = 1'b1;
    for (int i = 0; i < JOB_BOUND; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
    d_cyc = cyc; n_ops = op_cnt - op0; lsum = lat_sum - l0;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, err, pa_en} !== 4'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, err, pa_en});
    end
    tests++;
    if ({qx, qy, qz, qt} !== '0) begin
      fails++; $display("FAIL reset_q: got %h want 0", {qx, qy, qz, qt});
    end
    tests++;
    if ({pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2} !== '0) begin
      fails++; $display("FAIL reset_operands: got nonzero %h",
                        {pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2});
    end
  endtask

  task automatic test_fixed_k0();
    int s, d, nops, ls, op0, want_d;
    bit b1, e2, to;
    lat_min = 5; lat_max = 5; hold_cfg = 0;
    run_job('0, N'($urandom), N'($urandom), N'($urandom), N'($urandom),
            s, d, nops, ls, op0, b1, e2, to);
    want_d = 2 + KBITS * (2 * 6 + 1) + 1;
    tests++;
    if (to) begin fails++; $display("FAIL k0_done_timeout: no done within %0d cycles", JOB_BOUND); end
    tests++;
    if (d - s != want_d) begin fails++; $display("FAIL k0_latency: got %0d want %0d", d - s, want_d); end
    tests++;
    if (nops != 2 * KBITS) begin fails++; $display("FAIL k0_pulses: got %0d want %0d", nops, 2 * KBITS); end
    tests++;
    if ({qx, qy, qz, qt} !== {N'(0), N'(1), N'(1), N'(0)}) begin
      fails++; $display("FAIL k0_result: got %h %h %h %h want 0 1 1 0", qx, qy, qz, qt);
    end
    tests++;
    if (b1 !== 1'b1 || e2 !== 1'b1) begin
      fails++; $display("FAIL k0_start_timing: busy@1=%b pa_en@2=%b want 1 1", b1, e2);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL k0_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL k0_done_pulse: done still %b one cycle later", done); end
  endtask

  task automatic test_random_jobs(input int hold, input int lmin, input int lmax, input int njobs);
    logic [KBITS-1:0] kv [6];
    int s, d, nops, ls, op0, bad_dbl;
    bit b1, e2, to;
    logic [N-1:0] x, y, z, t, ex, ey, ez, et;
    kv[0] = KBITS'(1); kv[1] = '1; kv[2] = KBITS'(2);
    kv[3] = KBITS'($urandom); kv[4] = KBITS'($urandom); kv[5] = KBITS'($urandom);
    hold_cfg = hold; lat_min = lmin; lat_max = lmax;
    for (int j = 0; j < njobs; j++) begin
      x = N'($urandom); y = N'($urandom); z = N'($urandom); t = N'($urandom);
      ref_mult(kv[j], x, y, z, t, ex, ey, ez, et);
      run_job(kv[j], x, y, z, t, s, d, nops, ls, op0, b1, e2, to);
      tests++;
      if (to) begin fails++; $display("FAIL job%0d_h%0d_timeout: no done", j, hold); end
      tests++;
      if ({qx, qy, qz, qt} !== {ex, ey, ez, et}) begin
        fails++; $display("FAIL job%0d_h%0d_result k=%0d: got %h %h %h %h want %h %h %h %h",
                          j, hold, kv[j], qx, qy, qz, qt, ex, ey, ez, et);
      end
      tests++;
      if (nops != 2 * KBITS) begin fails++; $display("FAIL job%0d_h%0d_pulses: got %0d want %0d", j, hold, nops, 2 * KBITS); end
      tests++;
      if (d - s != 2 + ls + KBITS + 1) begin
        fails++; $display("FAIL job%0d_h%0d_latency: got %0d want %0d", j, hold, d - s, 2 + ls + KBITS + 1);
      end
      bad_dbl = 0;
      for (int b = 0; b < KBITS; b++) if (!dbl_eq[(op0 + 2 * b + 1) % 8192]) bad_dbl++;
      tests++;
      if (bad_dbl != 0) begin fails++; $display("FAIL job%0d_h%0d_double_operands: %0d unequal, want 0", j, hold, bad_dbl); end
    end
    hold_cfg = 0;
  endtask

  task automatic test_busy_ignore();
    logic [N-1:0] x, y, z, t, ex, ey, ez, et;
    logic [KBITS-1:0] ka;
    int op0;
    bit to;
    lat_min = 3; lat_max = 3; hold_cfg = 0;
    ka = KBITS'($urandom);
    x = N'($urandom); y = N'($urandom); z = N'($urandom); t = N'($urandom);
    ref_mult(ka, x, y, z, t, ex, ey, ez, et);
    @(negedge clk);
    k = ka; px = x; py = y; pz = z; pt = t; start = 1'b1; op0 = op_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    k = ~ka; px = ~x; py = ~y; start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < JOB_BOUND; i++) begin
      if (done) begin to = 1'b0; break; end
      @(negedge clk);
    end
    tests++;
    if (to) begin fails++; $display("FAIL busy_ignore_timeout: no done"); end
    tests++;
    if ({qx, qy, qz, qt} !== {ex, ey, ez, et}) begin
      fails++; $display("FAIL busy_ignore_result: got %h %h %h %h want %h %h %h %h", qx, qy, qz, qt, ex, ey, ez, et);
    end
    tests++;
    if (op_cnt - op0 != 2 * KBITS) begin fails++; $display("FAIL busy_ignore_pulses: got %0d want %0d", op_cnt - op0, 2 * KBITS); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_restart: busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    logic [N-1:0] x, y, z, t, ex, ey, ez, et;
    logic [KBITS-1:0] ka;
    int s, d, nops, ls, op0, e_cyc;
    bit b1, e2, to, saw_done;
    lat_min = 2; lat_max = 4; hold_cfg = 0;
    ka = KBITS'($urandom);
    x = N'($urandom); y = N'($urandom); z = N'($urandom); t = N'($urandom);
    ref_mult(ka, x, y, z, t, ex, ey, ez, et);
    run_job(ka, x, y, z, t, s, d, nops, ls, op0, b1, e2, to);
    never_rdy = 1'b1;
    @(negedge clk);
    k = ~ka; px = ~x; start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1; saw_done = 1'b0;
    for (int i = 0; i < 4 * TIMEOUT + 20; i++) begin
      if (done) saw_done = 1'b1;
      if (err) begin to = 1'b0; break; end
      @(negedge clk);
    end
    e_cyc = cyc;
    tests++;
    if (to) begin fails++; $display("FAIL timeout_no_err: err never pulsed"); end
    tests++;
    if (e_cyc - s != TIMEOUT + 4) begin fails++; $display("FAIL timeout_err_cycle: got %0d want %0d", e_cyc - s, TIMEOUT + 4); end
    tests++;
    if (busy !== 1'b0 || saw_done) begin fails++; $display("FAIL timeout_busy_done: busy=%b done_seen=%b want 0 0", busy, saw_done); end
    tests++;
    if ({qx, qy, qz, qt} !== {ex, ey, ez, et}) begin
      fails++; $display("FAIL timeout_q_held: got %h %h %h %h want %h %h %h %h", qx, qy, qz, qt, ex, ey, ez, et);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_pulse: err still %b", err); end
    never_rdy = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [N-1:0] x, y, z, t, ex, ey, ez, et;
    int s, d, nops, ls, op0;
    bit b1, e2, to, reached, flagged;
    lat_min = 2; lat_max = 5; hold_cfg = 0;
    @(negedge clk);
    k = KBITS'($urandom); px = N'($urandom); start = 1'b1; op0 = op_cnt;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < JOB_BOUND; i++) begin
      if (op_cnt - op0 >= KBITS + 1) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    tests++;
    if (!reached) begin fails++; $display("FAIL areset_midjob: job never reached middle"); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, pa_en} !== 4'b0 || {qx, qy, qz, qt} !== '0 ||
        {pa_x1, pa_y1, pa_z1, pa_t1, pa_x2, pa_y2, pa_z2, pa_t2} !== '0) begin
      fails++; $display("FAIL areset_outputs: ctrl=%b q=%h want all zero", {busy, done, err, pa_en}, {qx, qy, qz, qt});
    end
    flagged = 1'b0;
    repeat (4) begin @(negedge clk); if (done || err || busy) flagged = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done || err || busy) flagged = 1'b1; end
    tests++;
    if (flagged) begin fails++; $display("FAIL areset_no_pulse: done/err/busy seen after abort, want none"); end
    x = N'($urandom); y = N'($urandom); z = N'($urandom); t = N'($urandom);
    k = KBITS'($urandom);
    ref_mult(k, x, y, z, t, ex, ey, ez, et);
    run_job(k, x, y, z, t, s, d, nops, ls, op0, b1, e2, to);
    tests++;
    if (to || {qx, qy, qz, qt} !== {ex, ey, ez, et}) begin
      fails++; $display("FAIL areset_rerun: timeout=%b got %h %h %h %h want %h %h %h %h", to, qx, qy, qz, qt, ex, ey, ez, et);
    end
    tests++;
    if (nops != 2 * KBITS || d - s != 2 + ls + KBITS + 1) begin
      fails++; $display("FAIL areset_rerun_timing: pulses %0d latency %0d want %0d %0d", nops, d - s, 2 * KBITS, 2 + ls + KBITS + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_fixed_k0();
    test_random_jobs(0, 2, 6, 6);
    test_random_jobs(2, 5, 7, 3);
    test_busy_ignore();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scalar_mult_ctrl.md
# scalar_mult_ctrl

Sequencer that computes the Ed25519 scalar multiple k·P in extended coordinates by driving one shared `point_add` unit through a constant-time Montgomery ladder. It sits above `point_add`, owns the ladder registers R0/R1 and the scalar bit counter, and presents a start/done handshake to the signing/verification top level. Every scalar bit issues exactly two point additions regardless of bit value, so no timing leaks. Doubling reuses the complete addition formula with both operands equal.

## Interface
Parameters:
- N, 255, field element width
- KBITS, 255, scalar width; bits processed MSB first
- TIMEOUT, 1023, max cycles to wait for one `point_add` result before error

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin k·P; sampled only in IDLE
- k  in  KBITS  scalar, latched on accepted start
- px, py, pz, pt  in  N each  base point P, latched on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE/ERR cycle
- done  out  1  one-cycle pulse, result valid
- err  out  1  one-cycle pulse, `point_add` timeout
- qx, qy, qz, qt  out  N each  result k·P; held until next accepted start
- pa_en  out  1  one-cycle issue pulse to `point_add`
- pa_x1, pa_y1, pa_z1, pa_t1  out  N each  operand 1, stable from pa_en until capture
- pa_x2, pa_y2, pa_z2, pa_t2  out  N each  operand 2, stable from pa_en until capture
- pa_x3, pa_y3, pa_z3, pa_t3  in  N each  `point_add` result
- pa_rdy  in  1  `point_add` data_rdy (level)

## Operation
- States: IDLE, LOAD, ADD_ISSUE, ADD_WAIT, DBL_ISSUE, DBL_WAIT, NEXT, DONE, ERR.
- IDLE: start=1 → LOAD; latch k, P. start while busy is ignored.
- LOAD: R0 ← neutral (0,1,1,0); R1 ← P; bit index i ← KBITS-1. → ADD_ISSUE.
- ADD_ISSUE: pa_en=1, operands (R0, R1). → ADD_WAIT.
- ADD_WAIT: on rising edge of pa_rdy (pa_rdy=1 and registered pa_rdy=0), capture sum S: if k[i]=0, R1 ← S, else R0 ← S. → DBL_ISSUE.
- DBL_ISSUE: pa_en=1, both operands = R0 if k[i]=0, else R1 (value after ADD capture is irrelevant; doubled register is the one not overwritten). → DBL_WAIT.
- DBL_WAIT: on pa_rdy rising edge, k[i]=0: R0 ← result; k[i]=1: R1 ← result. → NEXT.
- NEXT: i=0 → DONE; else i ← i-1, → ADD_ISSUE.
- DONE: q* ← R0, done=1. → IDLE.
- Rising-edge detection on pa_rdy is mandatory: a level left high from the previous operation is never captured as a new result.
- Wait counter cleared on each pa_en, increments in *_WAIT; reaching TIMEOUT → ERR: err=1, q* unchanged. → IDLE.
- Operand muxing is pure selection; no field arithmetic in this block. k[i] is selected by index, not by shifting.

## Timing
- Reset: state IDLE; busy, done, err, pa_en = 0; q*, pa_* operands, R0, R1, counters = 0; registered pa_rdy = 0.
- Reset mid-operation aborts immediately; no done/err is produced. `point_add` is reset by the same rst_n.
- Accepted start at cycle 0: busy=1 at cycle 1 (LOAD), first pa_en at cycle 2.
- Per operation: 1 issue cycle + W wait cycles, where W counts up to and including the pa_rdy-edge cycle. 1 NEXT cycle per bit.
- Total from start to done = 2 + KBITS·(2·(1+W) + 1) + 1 cycles.
- Exactly 2·KBITS pa_en pulses per job, independent of k.
- Timeout: wait count reaches TIMEOUT with no edge → ERR at the next cycle.

## Test plan
- Stub `point_add` with fixed 5-cycle latency, KBITS=4, k=4'b0000 → q=(0,1,1,0), exactly 8 pa_en pulses, done at cycle 2+4·(2·6+1)+1=55.
- Real `point_add`, k=1, P=Ed25519 base point B → q projectively equals B (qx·Bz = Bx·qz mod p, same for y, t).
- k=2 and k=0x…ED−1 (ℓ−1) against golden model → 2B and −B respectively. Pulse count 2·KBITS in both cases.
- pa_rdy held high from the previous op into the next ADD_WAIT → no capture until pa_rdy drops and rises again.
- Stub never asserts pa_rdy → err pulse after TIMEOUT wait cycles, busy drops, q unchanged from prior job.
- Assert rst_n low midway through bit 100 → all outputs 0 asynchronously. A new start after release gives a correct result; start asserted while busy has no effect.
